mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multiply/divide unit owning the architectural HI/LO registers.
- Sits in the E stage beside the ALU. It executes MULT/MULTU/DIV/DIVU with configurable multi-cycle latency and MTHI/MTLO in one cycle.
- Serves MFHI/MFLO reads.
- Raises a stall request so the hazard logic freezes D when a HI/LO consumer meets a busy unit.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (at least 2).
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (at least 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (at least 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- start  input  1  E-stage instruction is a valid MDU op; sampled at the rising edge.
- mdOp  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- srcA  input  WIDTH  rs value (forwarded).
- srcB  input  WIDTH  rt value (forwarded).
- mdUse  input  1  D-stage instruction reads or writes HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
- readHi  input  1  selects HI (1) or LO (0) onto mdOut.
- busy  output  1  operation in flight.
- stall  output  1  equals mdUse AND (busy OR (start AND mdOp in 1..4)).
- hi  output  WIDTH  architectural HI.
- lo  output  WIDTH  architectural LO.
- mdOut  output  WIDTH  equals readHi ? hi : lo (combinational).

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, busy=0, internal counter=0, pending result discarded. Reset asserted mid-operation aborts the operation; HI/LO read 0 on the following cycle.
- Accept condition: start=1 and busy=0 at edge E0.
  - MULT/MULTU/DIV/DIVU: operands and the computed result are captured into internal temp registers; counter loads N-1 (N = MULT_CYCLES or DIV_CYCLES); busy=1 from E0.
  - MTHI: hi<=srcA at E0, busy stays 0.
  - MTLO: lo<=srcA at E0, busy stays 0.
- Busy phase: counter decrements each edge while busy. At the edge where counter==0, hi/lo are loaded from temp and busy<=0.
  - busy is high for exactly N cycles.
  - The new hi/lo are visible in the same cycle busy first reads 0.
  - Example, N=5 with accept at edge E0: busy high during E0..E5, hi/lo updated at E5.
- Arithmetic:
  - MULT: signed WIDTH x WIDTH to 2*WIDTH; hi = upper half, lo = lower half.
  - MULTU: same, unsigned.
  - DIV: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Signed overflow (MIN_INT / -1): lo=MIN_INT, hi=0.
  - Divide by zero (srcB=0, DIV or DIVU): busy still runs DIV_CYCLES cycles; hi/lo unchanged at completion.
- start while busy=1: ignored; hi/lo and counter unaffected. The hazard unit guarantees this never happens via stall. The bench flags it as a protocol error.
- mdOp NONE or 7 with start=1: no effect.
- stall is combinational. It covers both the op being accepted this cycle and an op already in flight.
- MTHI/MTLO alone never cause stall once accepted, because busy stays 0.
- hi, lo and busy are registered outputs. mdOut and stall are combinational.

Test Plan:
- MULT, MULT_CYCLES=5: srcA=0xFFFFFFFE (-2), srcB=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIV, DIV_CYCLES=10: -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1) after exactly 10 busy cycles.
- DIVU 7/0 with prior hi=0x11, lo=0x22 -> busy for 10 cycles, then hi=0x11, lo=0x22.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Hazard and control interaction:
  - mdUse=1 held through a MULT -> stall high from the accept cycle through the last busy cycle, low the cycle busy drops.
  - MTLO 0x1234 -> lo=0x1234 next cycle with no busy; with readHi=0, mdOut=0x1234.
  - start with DIV asserted while busy -> ignored.
  - reset asserted mid-DIV -> busy=0, hi=lo=0 the next cycle.
- Rerun the full suite with WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=1 -> 16-bit results correct; busy high for exactly 1 cycle.

Source files
------------

// File: rtl/mdu_unit.sv
// Multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at accept and held until the configured latency expires.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdOp,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             mdUse,
    input  logic             readHi,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mdOut
);
    // state  | meaning
    // S_IDLE | ready to accept; MTHI/MTLO complete here in one cycle
    // S_BUSY | MULT/DIV in flight; cnt_q counts down to the commit edge

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAXN = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
    logic             tmp_wr_q, tmp_wr_d;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               is_sdiv, a_neg, b_neg;
    logic [WIDTH-1:0]   dvd, dvs, dvs_safe, q_m, r_m, quo, rem;
    logic               is_md_op;

    assign prod_s = {{WIDTH{srcA[WIDTH-1]}}, srcA} * {{WIDTH{srcB[WIDTH-1]}}, srcB};
    assign prod_u = {{WIDTH{1'b0}}, srcA} * {{WIDTH{1'b0}}, srcB};

    // One unsigned divider serves both DIV and DIVU; signed operands go in as magnitudes.
    assign is_sdiv  = (mdOp == OP_DIV);
    assign a_neg    = is_sdiv & srcA[WIDTH-1];
    assign b_neg    = is_sdiv & srcB[WIDTH-1];
    assign dvd      = a_neg ? -srcA : srcA;
    assign dvs      = b_neg ? -srcB : srcB;
    assign dvs_safe = (dvs == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : dvs;
    assign q_m      = dvd / dvs_safe;
    assign r_m      = dvd % dvs_safe;
    assign quo      = (a_neg ^ b_neg) ? -q_m : q_m;
    assign rem      = a_neg ? -r_m : r_m;

    assign is_md_op = (mdOp >= OP_MULT) && (mdOp <= OP_DIVU);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        tmp_wr_d = tmp_wr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (mdOp)
                        OP_MULT, OP_MULTU: begin
                            tmp_hi_d = (mdOp == OP_MULT) ? prod_s[2*WIDTH-1:WIDTH] : prod_u[2*WIDTH-1:WIDTH];
                            tmp_lo_d = (mdOp == OP_MULT) ? prod_s[WIDTH-1:0] : prod_u[WIDTH-1:0];
                            tmp_wr_d = 1'b1;
                            cnt_d    = CW'(MULT_CYCLES - 1);
                            state_d  = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            tmp_hi_d = rem;
                            tmp_lo_d = quo;
                            // divide by zero still burns the full latency but leaves HI/LO alone
                            tmp_wr_d = (srcB != '0);
                            cnt_d    = CW'(DIV_CYCLES - 1);
                            state_d  = S_BUSY;
                        end
                        OP_MTHI: hi_d = srcA;
                        OP_MTLO: lo_d = srcA;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    if (tmp_wr_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
            tmp_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            tmp_wr_q <= tmp_wr_d;
        end
    end

    assign busy  = (state_q == S_BUSY);
    assign stall = mdUse & (busy | (start & is_md_op));
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign mdOut = readHi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: a 32-bit/5/10 instance and a 16-bit/1/1 instance run the same
// directed and random sequence against an arithmetic reference model.
module tb_mdu_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0, start0 = 1'b0, start1 = 1'b0, mdUse = 1'b0, readHi = 1'b0;
    logic [2:0]  mdOp = 3'd0;
    logic [31:0] srcA = '0, srcB = '0;
    logic        busy0, stall0, busy1, stall1;
    logic [31:0] hi0, lo0, mo0;
    logic [15:0] hi1, lo1, mo1;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .mdOp(mdOp), .srcA(srcA), .srcB(srcB),
        .mdUse(mdUse), .readHi(readHi), .busy(busy0), .stall(stall0), .hi(hi0), .lo(lo0), .mdOut(mo0));

    mdu_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .mdOp(mdOp), .srcA(srcA[15:0]), .srcB(srcB[15:0]),
        .mdUse(mdUse), .readHi(readHi), .busy(busy1), .stall(stall1), .hi(hi1), .lo(lo1), .mdOut(mo1));

    int checks = 0, errors = 0;
    int sel, w, nm, nd;
    logic [63:0] mask, m_hi, m_lo;

    function automatic logic [63:0] o_hi();    return sel != 0 ? 64'(hi1) : 64'(hi0); endfunction
    function automatic logic [63:0] o_lo();    return sel != 0 ? 64'(lo1) : 64'(lo0); endfunction
    function automatic logic [63:0] o_mdout(); return sel != 0 ? 64'(mo1) : 64'(mo0); endfunction
    function automatic logic o_busy();  return sel != 0 ? busy1 : busy0; endfunction
    function automatic logic o_stall(); return sel != 0 ? stall1 : stall0; endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (w=%0d) observed %h expected %h", tag, w, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) start1 = v; else start0 = v;
    endtask

    function automatic longint sx(input logic [63:0] v);
        logic signed [63:0] t;
        t = v << (64 - w);
        return t >>> (64 - w);
    endfunction

    // Reference: plain wide arithmetic on sign/zero-extended operands, then truncate to w bits.
    task automatic model(input int op, input logic [63:0] a, input logic [63:0] b,
                         output logic upd, output logic [63:0] nh, output logic [63:0] nl);
        longint p, q, r;
        logic [63:0] pu;
        upd = 1'b1; nh = m_hi; nl = m_lo;
        case (op)
            1: begin p = sx(a) * sx(b); nh = (p >> w) & mask; nl = p & mask; end
            2: begin pu = a * b; nh = (pu >> w) & mask; nl = pu & mask; end
            3: if (b == 0) upd = 1'b0;
               else begin q = sx(a) / sx(b); r = sx(a) % sx(b); nl = q & mask; nh = r & mask; end
            4: if (b == 0) upd = 1'b0;
               else begin nl = (a / b) & mask; nh = (a % b) & mask; end
            default: upd = 1'b0;
        endcase
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_hi"}, o_hi(), m_hi);
        chk({tag, "_lo"}, o_lo(), m_lo);
        chk({tag, "_mdout"}, o_mdout(), readHi ? m_hi : m_lo);
    endtask

    task automatic do_op(input int op, input logic [63:0] a_in, input logic [63:0] b_in,
                         input bit poke, input bit abort);
        logic [63:0] a, b, nh, nl;
        logic upd;
        int n, big_n;
        a = a_in & mask;
        b = b_in & mask;
        @(negedge clk);
        mdOp = 3'(op); srcA = a[31:0]; srcB = b[31:0]; readHi = 1'($urandom);
        set_start(1'b1);
        #1 chk("stall_accept", 64'(o_stall()), 64'(mdUse && op >= 1 && op <= 4));
        @(negedge clk);
        set_start(1'b0);
        #1;
        if (op >= 1 && op <= 4) begin
            model(op, a, b, upd, nh, nl);
            big_n = (op <= 2) ? nm : nd;
            if (abort) begin
                chk("abort_busy_before", 64'(o_busy()), 64'd1);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                #1;
                m_hi = '0; m_lo = '0;
                chk("abort_busy", 64'(o_busy()), 64'd0);
                check_regs("abort");
                return;
            end
            n = 0;
            while (o_busy() === 1'b1 && n < 200) begin
                chk("stall_busy", 64'(o_stall()), 64'(mdUse));
                if (poke && n == 0) begin
                    $display("note: protocol violation injected, start while busy should be ignored");
                    mdOp = 3'd3; srcA = $urandom; srcB = 32'd1;
                    set_start(1'b1);
                end else begin
                    set_start(1'b0);
                end
                n++;
                @(negedge clk);
            end
            set_start(1'b0);
            #1;
            chk("busy_cycles", 64'(n), 64'(big_n));
            if (upd) begin m_hi = nh; m_lo = nl; end
            check_regs("md_result");
            chk("stall_done", 64'(o_stall()), 64'd0);
        end else begin
            if (op == 5) m_hi = a;
            if (op == 6) m_lo = a;
            chk("mt_busy", 64'(o_busy()), 64'd0);
            chk("mt_stall", 64'(o_stall()), 64'd0);
            check_regs(op == 5 || op == 6 ? "mt" : "nop");
        end
    endtask

    task automatic run_suite();
        logic [63:0] a, b;
        int op;
        @(negedge clk);
        reset = 1'b1; mdUse = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        chk("rst_busy", 64'(o_busy()), 64'd0);
        chk("rst_stall", 64'(o_stall()), 64'd0);
        check_regs("rst");

        do_op(1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 0, 0);
        chk("mult_hi_k", o_hi(), mask);
        chk("mult_lo_k", o_lo(), mask & 64'hFFFF_FFFF_FFFF_FFFA);
        do_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        chk("multu_hi_k", o_hi(), mask - 64'd1);
        chk("multu_lo_k", o_lo(), 64'd1);
        do_op(3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 0);
        chk("div_lo_k", o_lo(), mask & 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_hi_k", o_hi(), mask);
        mdUse = 1'b0;
        do_op(6, 64'h1234, 64'd0, 0, 0);
        readHi = 1'b0;
        #1 chk("mtlo_mdout_k", o_mdout(), 64'h1234);
        do_op(5, 64'h11, 64'd0, 0, 0);
        do_op(6, 64'h22, 64'd0, 0, 0);
        mdUse = 1'b1;
        do_op(4, 64'd7, 64'd0, 0, 0);
        chk("divu0_hi_k", o_hi(), 64'h11);
        chk("divu0_lo_k", o_lo(), 64'h22);
        do_op(3, 64'd1 << (w - 1), 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        chk("ovf_lo_k", o_lo(), 64'd1 << (w - 1));
        chk("ovf_hi_k", o_hi(), 64'd0);
        do_op(3, 64'd100, 64'd7, 1, 0);
        do_op(0, 64'd5, 64'd5, 0, 0);
        do_op(7, 64'd5, 64'd5, 0, 0);

        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 7);
            a = {32'h0, $urandom};
            b = ($urandom_range(0, 5) == 0) ? 64'd0 : {32'h0, $urandom};
            if ($urandom_range(0, 3) == 0) b = b & 64'hF;
            mdUse = 1'($urandom);
            do_op(op, a, b, 0, 0);
        end
        mdUse = 1'b1;
        do_op(3, 64'd1000, 64'd3, 0, 1);
    endtask

    initial begin
        sel = 0; w = 32; nm = 5; nd = 10; mask = (64'd1 << w) - 64'd1;
        run_suite();
        sel = 1; w = 16; nm = 1; nd = 1; mask = (64'd1 << w) - 64'd1;
        run_suite();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
